stopwatch_cmd_arbiter: RTL and testbench

STOPWATCH_CMD_ARBITER -- requirements
Module: stopwatch_cmd_arbiter

---
 rtl/stopwatch_cmd_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_stopwatch_cmd_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_cmd_arbiter
// Purpose  : Round-robin arbiter between the front panel (requester 0) and
//            the host (requester 1) for stopwatch commands. Each granted
//            command is checked against the live datapath status. Legal
//            start/stop/reset commands become single-cycle pulses. Legal lap
//            commands capture the live time into lap storage.
// Config   : `define STOPWATCH_LAP_FIFO_EN -> lap storage is a LAP_DEPTH-deep
//            FIFO (oldest entry first). When it is undefined, lap storage is
//            a single overwrite register. The ports are the same in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_cmd_arbiter #(
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_cmd,
  output logic [1:0]  req_ready,
  output logic        sw_start,
  output logic        sw_stop,
  output logic        sw_reset,
  input  logic [1:0]  sw_status,
  input  logic [7:0]  sw_minutes,
  input  logic [5:0]  sw_seconds,
  output logic        cmd_err,
  output logic [13:0] lap_data,
  output logic        lap_valid,
  input  logic        lap_ready,
  output logic        lap_ovf
);

  localparam logic [1:0] C_CMD_START = 2'b00;
  localparam logic [1:0] C_CMD_STOP  = 2'b01;
  localparam logic [1:0] C_CMD_RESET = 2'b10;
  localparam logic [1:0] C_CMD_LAP   = 2'b11;

  localparam logic [1:0] C_ST_RUNNING = 2'b01;
  localparam logic [1:0] C_ST_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Reject unsupported lap depths at elaboration.
  if (LAP_DEPTH < 2 || LAP_DEPTH > 16 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0) begin : g_bad_lap_depth
    $error("LAP_DEPTH must be a power of two in the range 2..16");
  end

  state_t     r_state;
  logic       r_ptr;
  logic       r_grant;
  logic [1:0] r_cmd;

  logic       w_pick;
  logic       w_issue;
  logic       w_legal;
  logic       w_push;
  logic       w_clear;
  logic       w_pop;
  logic [13:0] w_lap_in;

  // Winner among valid requesters: the pointer breaks a tie.
  always_comb begin
    w_pick = 1'b0;
    if (req_valid == 2'b11) begin
      w_pick = r_ptr;
    end else begin
      w_pick = req_valid[1];
    end
  end

  // Arbitration FSM: capture the grant and command, issue for one cycle, then settle for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
      r_ptr   <= 1'b0;
      r_grant <= 1'b0;
      r_cmd   <= 2'b00;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (|req_valid) begin
            r_grant <= w_pick;
            r_cmd   <= w_pick ? req_cmd[3:2] : req_cmd[1:0];
            r_ptr   <= ~w_pick;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE:  r_state <= ST_SETTLE;
        ST_SETTLE: r_state <= ST_ARB;
        default:   r_state <= ST_ARB;
      endcase
    end
  end

  // The legality check uses the status seen in the ISSUE cycle, so the pulses
  // decode the registered state against live status. rst masks them so an
  // aborted command is neither consumed nor pulsed.
  assign w_issue = (r_state == ST_ISSUE) && !rst;

  // Command legality against the current datapath state (status 11 counts as IDLE).
  always_comb begin
    w_legal = 1'b0;
    case (r_cmd)
      C_CMD_START: w_legal = (sw_status != C_ST_RUNNING);
      C_CMD_STOP:  w_legal = (sw_status == C_ST_RUNNING);
      C_CMD_RESET: w_legal = 1'b1;
      C_CMD_LAP:   w_legal = (sw_status == C_ST_RUNNING);
      default:     w_legal = 1'b0;
    endcase
  end

  assign req_ready = w_issue ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign sw_start  = w_issue && w_legal && (r_cmd == C_CMD_START);
  assign sw_stop   = w_issue && w_legal && (r_cmd == C_CMD_STOP);
  assign sw_reset  = w_issue && (r_cmd == C_CMD_RESET);
  assign cmd_err   = w_issue && !w_legal;

  assign w_push   = w_issue && w_legal && (r_cmd == C_CMD_LAP);
  assign w_clear  = w_issue && (r_cmd == C_CMD_RESET);
  assign w_pop    = lap_valid && lap_ready;
  assign w_lap_in = {sw_minutes, sw_seconds};

`ifdef STOPWATCH_LAP_FIFO_EN
  localparam int AW = $clog2(LAP_DEPTH);
  localparam logic [AW:0] C_FULL = LAP_DEPTH[AW:0];

  logic [13:0]   r_mem [LAP_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full;
  logic          w_do_push;
  logic          w_drop;

  // A pop in the same cycle makes room, so a full FIFO still accepts that push.
  assign w_full    = (r_count == C_FULL);
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // FIFO pointers, occupancy and the sticky overflow flag. A reset command empties the FIFO and takes priority over a push or pop.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Lap storage array. Entries outside the valid window are never read, so the array has no reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !w_clear) begin
      r_mem[r_wr] <= w_lap_in;
    end
  end

  assign lap_valid = (r_count != '0);
  assign lap_data  = lap_valid ? r_mem[r_rd] : 14'd0;
  assign lap_ovf   = r_ovf;
`else
  logic [13:0] r_lap;
  logic        r_valid;
  logic        r_ovf;

  // Single lap register: a newer lap overwrites an unread one and flags the loss.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_lap   <= 14'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_push) begin
      r_lap   <= w_lap_in;
      r_valid <= 1'b1;
      if (r_valid && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign lap_valid = r_valid;
  assign lap_data  = r_valid ? r_lap : 14'd0;
  assign lap_ovf   = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_cmd_arbiter
// Purpose  : Scoreboard bench for stopwatch_cmd_arbiter. Stimulus pushes the
//            expected ISSUE-cycle outputs and the expected popped laps. A
//            monitor compares them whenever the DUT shows a handshake.
//            Lap expectations follow STOPWATCH_LAP_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_cmd_arbiter;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;
  localparam logic [1:0] CMD_LAP   = 2'b11;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSE  = 2'b10;
  localparam logic [1:0] ST_ODD    = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req_cmd = 4'h0;
  logic [1:0]  req_ready;
  logic        sw_start, sw_stop, sw_reset, cmd_err;
  logic [1:0]  sw_status = 2'b00;
  logic [7:0]  sw_minutes = 8'd0;
  logic [5:0]  sw_seconds = 6'd0;
  logic [13:0] lap_data;
  logic        lap_valid;
  logic        lap_ready = 1'b0;
  logic        lap_ovf;

  stopwatch_cmd_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .sw_start(sw_start), .sw_stop(sw_stop),
    .sw_reset(sw_reset), .sw_status(sw_status), .sw_minutes(sw_minutes),
    .sw_seconds(sw_seconds), .cmd_err(cmd_err), .lap_data(lap_data),
    .lap_valid(lap_valid), .lap_ready(lap_ready), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] rdy;
    logic       st;
    logic       sp;
    logic       rs;
    logic       er;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] lap_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          n_cmd  = 0;
  exp_t        mon_e;
  logic [13:0] mon_lap;

  // Monitor: every ISSUE-cycle handshake or pulse, and every lap pop, is compared against the scoreboard.
  always @(negedge clk) begin
    if (req_ready != 2'b00 || sw_start || sw_stop || sw_reset || cmd_err) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got ready=%b start=%b stop=%b reset=%b err=%b at cycle %0d, want no activity",
                 req_ready, sw_start, sw_stop, sw_reset, cmd_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (req_ready !== mon_e.rdy || sw_start !== mon_e.st || sw_stop !== mon_e.sp ||
            sw_reset !== mon_e.rs || cmd_err !== mon_e.er || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL cmd_out[%0d]: got ready=%b start=%b stop=%b reset=%b err=%b cyc=%0d, want ready=%b start=%b stop=%b reset=%b err=%b cyc=%0d",
                   n_cmd, req_ready, sw_start, sw_stop, sw_reset, cmd_err, cyc,
                   mon_e.rdy, mon_e.st, mon_e.sp, mon_e.rs, mon_e.er, mon_e.cyc);
        end
      end
      n_cmd++;
    end
    if (lap_valid && lap_ready) begin
      n_vec++;
      if (lap_q.size() == 0) begin
        n_fail++;
        $display("FAIL lap_unexpected_pop: got lap_data=%h, want no pop", lap_data);
      end else begin
        mon_lap = lap_q.pop_front();
        if (lap_data !== mon_lap) begin
          n_fail++;
          $display("FAIL lap_pop: got lap_data=%h, want %h", lap_data, mon_lap);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] rdy, input logic st, input logic sp,
                              input logic rs, input logic er, input int c);
    exp_t e;
    e.rdy = rdy; e.st = st; e.sp = sp; e.rs = rs; e.er = er; e.cyc = c;
    return e;
  endfunction

  // Present one command from one requester while the FSM is in ARB. Optionally pop a lap during ISSUE. Ends in the next ARB cycle.
  task automatic issue(input int who, input logic [1:0] cmd, input logic [1:0] st,
                       input logic [7:0] mm, input logic [5:0] ss, input logic lr,
                       input logic e_st, input logic e_sp, input logic e_rs, input logic e_er);
    sw_status  = st;
    sw_minutes = mm;
    sw_seconds = ss;
    req_valid  = (who == 0) ? 2'b01 : 2'b10;
    req_cmd    = (who == 0) ? {2'b00, cmd} : {cmd, 2'b00};
    sb.push_back(mk(req_valid, e_st, e_sp, e_rs, e_er, cyc + 1));
    @(posedge clk); #1;
    lap_ready = lr;
    @(posedge clk); #1;
    lap_ready = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    lap_ready = 1'b1;
    @(posedge clk); #1;
    lap_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset state
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_pulses", {28'd0, sw_start, sw_stop, sw_reset, cmd_err}, 32'd0);
    check("rst_lap_valid", {31'd0, lap_valid}, 32'd0);
    check("rst_lap_data", {18'd0, lap_data}, 32'd0);
    check("rst_lap_ovf", {31'd0, lap_ovf}, 32'd0);

    // Single-requester legality sweep
    issue(0, CMD_START, ST_IDLE,  8'd0, 6'd0, 1'b0, 1, 0, 0, 0);
    issue(1, CMD_START, ST_ODD,   8'd0, 6'd0, 1'b0, 1, 0, 0, 0);
    issue(0, CMD_STOP,  ST_IDLE,  8'd0, 6'd0, 1'b0, 0, 0, 0, 1);
    issue(1, CMD_START, ST_RUN,   8'd0, 6'd0, 1'b0, 0, 0, 0, 1);
    issue(0, CMD_LAP,   ST_IDLE,  8'd2, 6'd5, 1'b0, 0, 0, 0, 1);
    issue(1, CMD_LAP,   ST_PAUSE, 8'd2, 6'd6, 1'b0, 0, 0, 0, 1);
    issue(0, CMD_START, ST_PAUSE, 8'd0, 6'd0, 1'b0, 1, 0, 0, 0);
    issue(0, CMD_STOP,  ST_PAUSE, 8'd0, 6'd0, 1'b0, 0, 0, 0, 1);
    issue(0, CMD_STOP,  ST_RUN,   8'd0, 6'd0, 1'b0, 0, 1, 0, 0);
    issue(1, CMD_RESET, ST_RUN,   8'd0, 6'd0, 1'b0, 0, 0, 1, 0);
    check("illegal_lap_no_push", {31'd0, lap_valid}, 32'd0);

    // Both valid continuously: grants alternate 0,1,0,1,0, spaced 3 cycles apart
    sw_status  = ST_RUN;
    sw_minutes = 8'd1;
    sw_seconds = 6'd10;
    req_valid  = 2'b11;
    req_cmd    = {CMD_LAP, CMD_STOP};
    sb.push_back(mk(2'b01, 0, 1, 0, 0, cyc + 1));
    sb.push_back(mk(2'b10, 0, 0, 0, 0, cyc + 4));
    sb.push_back(mk(2'b01, 0, 1, 0, 0, cyc + 7));
    sb.push_back(mk(2'b10, 0, 0, 0, 0, cyc + 10));
    sb.push_back(mk(2'b01, 0, 1, 0, 0, cyc + 13));
    repeat (7) @(posedge clk);
    #1;
    sw_seconds = 6'd20;
    repeat (7) @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("two_laps_valid", {31'd0, lap_valid}, 32'd1);
`ifdef STOPWATCH_LAP_FIFO_EN
    check("two_laps_oldest", {18'd0, lap_data}, {18'd0, 8'd1, 6'd10});
    check("two_laps_ovf", {31'd0, lap_ovf}, 32'd0);
`else
    check("two_laps_reg", {18'd0, lap_data}, {18'd0, 8'd1, 6'd20});
    check("two_laps_ovf", {31'd0, lap_ovf}, 32'd1);
`endif

    // A reset command clears lap storage and overflow; a later pop does nothing
    issue(1, CMD_RESET, ST_RUN, 8'd0, 6'd0, 1'b0, 0, 0, 1, 0);
    check("clr_lap_valid", {31'd0, lap_valid}, 32'd0);
    check("clr_lap_ovf", {31'd0, lap_ovf}, 32'd0);
    check("clr_lap_data", {18'd0, lap_data}, 32'd0);
    pop_one();
    check("clr_pop_no_effect", {31'd0, lap_valid}, 32'd0);

    // rst during ISSUE aborts the command and returns the pointer to requester 0
    sw_status = ST_IDLE;
    req_valid = 2'b01;
    req_cmd   = {2'b00, CMD_START};
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_pulses", {28'd0, sw_start, sw_stop, sw_reset, cmd_err}, 32'd0);
    sw_status = ST_PAUSE;
    req_valid = 2'b11;
    req_cmd   = {CMD_RESET, CMD_START};
    sb.push_back(mk(2'b01, 1, 0, 0, 0, cyc + 1));
    sb.push_back(mk(2'b10, 0, 0, 1, 0, cyc + 4));
    repeat (5) @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Five laps while running with no pops
    for (int i = 0; i < 5; i++) begin
      issue(1, CMD_LAP, ST_RUN, 8'd0, 6'(3 + 4 * i), 1'b0, 0, 0, 0, 0);
    end
    check("five_laps_ovf", {31'd0, lap_ovf}, 32'd1);
`ifdef STOPWATCH_LAP_FIFO_EN
    lap_q.push_back({8'd0, 6'd3});
    lap_q.push_back({8'd0, 6'd7});
    lap_q.push_back({8'd0, 6'd11});
    lap_q.push_back({8'd0, 6'd15});
    repeat (4) pop_one();
`else
    lap_q.push_back({8'd0, 6'd19});
    pop_one();
`endif
    check("five_laps_drained", {31'd0, lap_valid}, 32'd0);
    check("ovf_sticky", {31'd0, lap_ovf}, 32'd1);

    // Push and pop in the same cycle keep the occupancy unchanged
    issue(0, CMD_RESET, ST_IDLE, 8'd0, 6'd0, 1'b0, 0, 0, 1, 0);
    check("ovf_cleared", {31'd0, lap_ovf}, 32'd0);
    issue(0, CMD_LAP, ST_RUN, 8'd0, 6'd21, 1'b0, 0, 0, 0, 0);
    lap_q.push_back({8'd0, 6'd21});
    issue(0, CMD_LAP, ST_RUN, 8'd0, 6'd33, 1'b1, 0, 0, 0, 0);
    check("pushpop_valid", {31'd0, lap_valid}, 32'd1);
    check("pushpop_data", {18'd0, lap_data}, {18'd0, 8'd0, 6'd33});
    check("pushpop_ovf", {31'd0, lap_ovf}, 32'd0);
    lap_q.push_back({8'd0, 6'd33});
    pop_one();
    check("pushpop_drained", {31'd0, lap_valid}, 32'd0);

    // A reset command in the same cycle as a pop: the clear wins
    issue(1, CMD_LAP, ST_RUN, 8'd3, 6'd45, 1'b0, 0, 0, 0, 0);
    lap_q.push_back({8'd3, 6'd45});
    issue(1, CMD_RESET, ST_RUN, 8'd0, 6'd0, 1'b1, 0, 0, 1, 0);
    check("clr_vs_pop_valid", {31'd0, lap_valid}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    check("lap_q_drained", lap_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
